// File: rtl/params_mon_pkg.sv
// Shared types and constants for the parameter-echo monitor: FSM states,
// field indices and the snapshot layout of the six monitored inputs.
package params_mon_pkg;

   typedef enum logic [1:0] {
      SETTLE = 2'd0,
      SCAN   = 2'd1,
      PASS   = 2'd2,
      FAIL   = 2'd3
   } state_t;

   localparam int NFIELDS = 6;
   localparam int IDX_BOO = 0;
   localparam int IDX_INT = 1;
   localparam int IDX_LOG = 2;
   localparam int IDX_VEC = 3;
   localparam int IDX_STR = 4;
   localparam int IDX_REA = 5;

   // First member is the MSB, so {rea,str,vec,log,int,boo} packs directly.
   typedef struct packed {
      logic       rea;
      logic       str;
      logic [7:0] vec;
      logic       log;
      logic [7:0] int_f;
      logic       boo;
   } snap_t;

   function automatic logic [NFIELDS-1:0] field_mismatch(
      input snap_t      s,
      input logic [7:0] exp_int,
      input logic [7:0] exp_vec
   );
      logic [NFIELDS-1:0] m;
      m          = '0;
      m[IDX_BOO] = (s.boo   != 1'b1);
      m[IDX_INT] = (s.int_f != exp_int);
      m[IDX_LOG] = (s.log   != 1'b1);
      m[IDX_VEC] = (s.vec   != exp_vec);
      m[IDX_STR] = (s.str   != 1'b1);
      m[IDX_REA] = (s.rea   != 1'b1);
      return m;
   endfunction

endpackage

// File: rtl/params_mon_blink.sv
// LED blink divider: counts 0..BLINK_DIV-1 while enabled and flips its
// output on each wrap; a synchronous clear returns it to the idle state.
module params_mon_blink #(
   parameter int BLINK_DIV = 25000000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   input  logic clr_i,
   output logic toggle_o
);

   localparam int CW = $clog2(BLINK_DIV);

   logic [CW-1:0] r_cnt;
   logic          r_toggle;

   // NOTE: registers use non-blocking assignments so every flop samples
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt    <= '0;
         r_toggle <= 1'b0;
      end else if (clr_i) begin
         r_cnt    <= '0;
         r_toggle <= 1'b0;
      end else if (en_i) begin
         if (r_cnt == CW'(BLINK_DIV - 1)) begin
            r_cnt    <= '0;
            r_toggle <= ~r_toggle;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign toggle_o = r_toggle;

endmodule

// File: rtl/params_monitor.sv
// Settles, scans and then continuously watches the six parameter echoes.
// Optional PASS/SCAN->FAIL event counter enabled by PARAMS_MON_ERRCNT_EN.
module params_monitor
   import params_mon_pkg::*;
#(
   parameter logic [7:0] EXP_INT    = 8'd92,
   parameter logic [7:0] EXP_VEC    = 8'b1100_1100,
   parameter int         STABLE_CYC = 16,
   parameter int         BLINK_DIV  = 25000000
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       boo_i,
   input  logic [7:0] int_i,
   input  logic       log_i,
   input  logic [7:0] vec_i,
   input  logic       str_i,
   input  logic       rea_i,
   input  logic       restart_i,
   output logic       done_o,
   output logic       pass_o,
   output logic [5:0] fail_mask_o,
   output logic       led_o,
   output logic [7:0] err_cnt_o
);

   localparam int SCW = $clog2(STABLE_CYC + 1);

   snap_t              w_in;
   snap_t              r_in_q;
   state_t             r_state,    w_state_nxt;
   logic [SCW-1:0]     r_stab_cnt, w_stab_nxt;
   logic [2:0]         r_idx,      w_idx_nxt;
   logic [NFIELDS-1:0] r_mask,     w_mask_nxt;
   logic [NFIELDS-1:0] w_mis;
   logic               w_blink_en;
   logic               w_blink;

   assign w_in  = {rea_i, str_i, vec_i, log_i, int_i, boo_i};
   assign w_mis = field_mismatch(r_in_q, EXP_INT, EXP_VEC);

   // NOTE: every register, including the snapshot, gets a reset value so
   // the first settle window always starts from a known all-zero history.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_in_q     <= '0;
         r_state    <= SETTLE;
         r_stab_cnt <= '0;
         r_idx      <= '0;
         r_mask     <= '0;
      end else begin
         r_in_q     <= w_in;
         r_state    <= w_state_nxt;
         r_stab_cnt <= w_stab_nxt;
         r_idx      <= w_idx_nxt;
         r_mask     <= w_mask_nxt;
      end
   end

   // NOTE: all outputs of this block are defaulted first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_stab_nxt  = r_stab_cnt;
      w_idx_nxt   = r_idx;
      w_mask_nxt  = r_mask;
      if (restart_i) begin
         w_state_nxt = SETTLE;
         w_stab_nxt  = '0;
         w_idx_nxt   = '0;
         w_mask_nxt  = '0;
      end else begin
         unique case (r_state)
            SETTLE: begin
               // Stable means the value about to be captured equals the snapshot.
               if (w_in == r_in_q) begin
                  if (r_stab_cnt == SCW'(STABLE_CYC - 1)) begin
                     w_state_nxt = SCAN;
                     w_stab_nxt  = '0;
                     w_idx_nxt   = '0;
                  end else begin
                     w_stab_nxt = r_stab_cnt + 1'b1;
                  end
               end else begin
                  w_stab_nxt = '0;
               end
            end
            SCAN: begin
               w_mask_nxt[r_idx] = w_mis[r_idx];
               if (r_idx == 3'(NFIELDS - 1)) begin
                  w_state_nxt = (w_mask_nxt == '0) ? PASS : FAIL;
                  w_idx_nxt   = '0;
               end else begin
                  w_idx_nxt = r_idx + 1'b1;
               end
            end
            PASS: begin
               if (w_mis != '0) begin
                  w_state_nxt = FAIL;
                  w_mask_nxt  = w_mis;
               end
            end
            FAIL: begin
               w_state_nxt = FAIL;
            end
            default: begin
               w_state_nxt = SETTLE;
            end
         endcase
      end
   end

   assign w_blink_en = (r_state == PASS);

   params_mon_blink #(
      .BLINK_DIV (BLINK_DIV)
   ) u_blink (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .en_i     (w_blink_en),
      .clr_i    (restart_i),
      .toggle_o (w_blink)
   );

`ifdef PARAMS_MON_ERRCNT_EN
   logic [7:0] r_err_cnt;
   logic       w_to_fail;

   // A restart forces SETTLE, so a fail suppressed by restart is not counted.
   assign w_to_fail = (w_state_nxt == FAIL) && (r_state != FAIL);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_err_cnt <= '0;
      end else if (w_to_fail && (r_err_cnt != 8'hFF)) begin
         r_err_cnt <= r_err_cnt + 1'b1;
      end
   end

   assign err_cnt_o = r_err_cnt;
`else
   assign err_cnt_o = 8'd0;
`endif

   assign done_o      = (r_state == PASS) || (r_state == FAIL);
   assign pass_o      = (r_state == PASS);
   assign fail_mask_o = r_mask;
   assign led_o       = (r_state == FAIL) || ((r_state == PASS) && w_blink);

endmodule

// File: tb/tb_params_monitor.sv
// Bench for params_monitor: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_params_monitor;

   localparam int STABLE_CYC = 4;
   localparam int BLINK_DIV  = 4;
   localparam int NF         = 6;

   localparam int M_SETTLE = 0;
   localparam int M_SCAN   = 1;
   localparam int M_PASS   = 2;
   localparam int M_FAIL   = 3;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic       boo_i, log_i, str_i, rea_i, restart_i;
   logic [7:0] int_i, vec_i;
   logic       done_o, pass_o, led_o;
   logic [5:0] fail_mask_o;
   logic [7:0] err_cnt_o;

   int n_checks = 0;
   int n_errors = 0;

   // Field order boo,int,log,vec,str,rea
   int unsigned gold [NF] = '{1, 92, 1, 'hCC, 1, 1};

   // Behavioural model state
   int unsigned m_snap [NF];
   int          m_mode, m_run, m_pos, m_blink, m_err;
   logic [5:0]  m_mask;
   logic        m_led;

   params_monitor #(
      .EXP_INT    (8'd92),
      .EXP_VEC    (8'hCC),
      .STABLE_CYC (STABLE_CYC),
      .BLINK_DIV  (BLINK_DIV)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .boo_i       (boo_i),
      .int_i       (int_i),
      .log_i       (log_i),
      .vec_i       (vec_i),
      .str_i       (str_i),
      .rea_i       (rea_i),
      .restart_i   (restart_i),
      .done_o      (done_o),
      .pass_o      (pass_o),
      .fail_mask_o (fail_mask_o),
      .led_o       (led_o),
      .err_cnt_o   (err_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < NF; k++) m_snap[k] = 0;
      m_mode  = M_SETTLE;
      m_run   = 0;
      m_pos   = 0;
      m_blink = 0;
      m_err   = 0;
      m_mask  = '0;
      m_led   = 1'b0;
   endtask

   task automatic model_step();
      int unsigned cur [NF];
      logic [5:0]  mis;
      bit          same;
      cur[0] = boo_i; cur[1] = int_i; cur[2] = log_i;
      cur[3] = vec_i; cur[4] = str_i; cur[5] = rea_i;
      same = 1'b1;
      for (int k = 0; k < NF; k++) begin
         mis[k] = (m_snap[k] != gold[k]);
         if (cur[k] != m_snap[k]) same = 1'b0;
      end
      if (restart_i) begin
         m_mode  = M_SETTLE;
         m_run   = 0;
         m_mask  = '0;
         m_blink = 0;
         m_led   = 1'b0;
      end else begin
         case (m_mode)
            M_SETTLE: begin
               m_run = same ? m_run + 1 : 0;
               if (m_run == STABLE_CYC) begin
                  m_mode = M_SCAN;
                  m_pos  = 0;
                  m_run  = 0;
               end
            end
            M_SCAN: begin
               if (mis[m_pos]) m_mask[m_pos] = 1'b1;
               m_pos++;
               if (m_pos == NF) begin
                  if (m_mask != 0) begin
                     m_mode = M_FAIL;
                     if (m_err < 255) m_err++;
                  end else begin
                     m_mode = M_PASS;
                  end
               end
            end
            M_PASS: begin
               if (mis != 0) begin
                  m_mode = M_FAIL;
                  m_mask = mis;
                  if (m_err < 255) m_err++;
               end else begin
                  m_blink++;
                  if (m_blink == BLINK_DIV) begin
                     m_blink = 0;
                     m_led   = ~m_led;
                  end
               end
            end
            default: ;
         endcase
      end
      for (int k = 0; k < NF; k++) m_snap[k] = cur[k];
   endtask

   function automatic logic [7:0] exp_err(input int e);
`ifdef PARAMS_MON_ERRCNT_EN
      return 8'(e);
`else
      return (e >= 0) ? 8'd0 : 8'd0;
`endif
   endfunction

   initial begin
      model_reset();
      forever begin
         @(posedge clk_i or negedge rst_ni);
         if (!rst_ni) model_reset();
         else model_step();
      end
   end

   // Per-cycle comparison against the model
   initial begin
      forever begin
         @(negedge clk_i);
         check("done",  32'(done_o),      32'(m_mode == M_PASS || m_mode == M_FAIL));
         check("pass",  32'(pass_o),      32'(m_mode == M_PASS));
         check("mask",  32'(fail_mask_o), 32'(m_mask));
         check("led",   32'(led_o),       32'((m_mode == M_FAIL) || (m_mode == M_PASS && m_led)));
         check("err",   32'(err_cnt_o),   32'(exp_err(m_err)));
      end
   end

   task automatic apply(input int unsigned f [NF]);
      boo_i = f[0][0];
      int_i = f[1][7:0];
      log_i = f[2][0];
      vec_i = f[3][7:0];
      str_i = f[4][0];
      rea_i = f[5][0];
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_ni = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   // Returns at the falling edge after the n-th rising edge from now.
   task automatic edges(input int n);
      repeat (n) @(posedge clk_i);
      @(negedge clk_i);
   endtask

   initial begin
      int unsigned pat [NF];
      restart_i = 1'b0;
      apply(gold);
      repeat (2) @(negedge clk_i);
      check("rst_done", 32'(done_o), 0);
      check("rst_pass", 32'(pass_o), 0);
      check("rst_mask", 32'(fail_mask_o), 0);
      check("rst_led",  32'(led_o), 0);
      check("rst_err",  32'(err_cnt_o), 0);

      // Golden: done on edge 11, led toggles every 4 edges
      apply(gold);
      do_reset();
      edges(10); check("t1_done_e10", 32'(done_o), 0);
      edges(1);  check("t1_done_e11", 32'(done_o), 1);
      check("t1_pass", 32'(pass_o), 1);
      check("t1_mask", 32'(fail_mask_o), 0);
      check("t1_led_e11", 32'(led_o), 0);
      edges(3);  check("t1_led_e14", 32'(led_o), 0);
      edges(1);  check("t1_led_e15", 32'(led_o), 1);
      edges(4);  check("t1_led_e19", 32'(led_o), 0);

      // int_i off by one
      pat = gold; pat[1] = 91;
      apply(pat);
      do_reset();
      edges(11);
      check("t2_done", 32'(done_o), 1);
      check("t2_pass", 32'(pass_o), 0);
      check("t2_mask", 32'(fail_mask_o), 32'h02);
      check("t2_led",  32'(led_o), 1);

      // vec_i corrected after edge 2 restarts the settle window
      pat = gold; pat[3] = 0;
      apply(pat);
      do_reset();
      edges(2);
      vec_i = 8'hCC;
      edges(10); check("t3_done_e12", 32'(done_o), 0);
      edges(1);  check("t3_done_e13", 32'(done_o), 1);
      check("t3_pass", 32'(pass_o), 1);

      // Loss of rea_i while passing: captured next edge, FAIL on the one after
      rea_i = 1'b0;
      edges(1); check("t4_pass_hold", 32'(pass_o), 1);
      edges(1);
      check("t4_pass", 32'(pass_o), 0);
      check("t4_done", 32'(done_o), 1);
      check("t4_mask", 32'(fail_mask_o), 32'h20);
      check("t4_led",  32'(led_o), 1);
      check("t4_err",  32'(err_cnt_o), 32'(exp_err(1)));

      // Restart during scan index 3 with every field wrong
      pat = '{0, 1, 0, 1, 0, 0};
      apply(pat);
      do_reset();
      edges(8); check("t5_partial_mask", 32'(fail_mask_o), 32'h07);
      restart_i = 1'b1;
      edges(1);
      restart_i = 1'b0;
      check("t5_mask_clr", 32'(fail_mask_o), 0);
      check("t5_done_clr", 32'(done_o), 0);
      edges(9);  check("t5_done_early", 32'(done_o), 0);
      edges(1);  check("t5_done", 32'(done_o), 1);
      check("t5_mask", 32'(fail_mask_o), 32'h3F);

      // Asynchronous reset while blinking
      apply(gold);
      do_reset();
      edges(15);
      check("t6_led_on", 32'(led_o), 1);
      @(posedge clk_i);
      #2 rst_ni = 1'b0;
      #1;
      check("t6_done", 32'(done_o), 0);
      check("t6_pass", 32'(pass_o), 0);
      check("t6_mask", 32'(fail_mask_o), 0);
      check("t6_led",  32'(led_o), 0);
      check("t6_err",  32'(err_cnt_o), 0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      // Randomized traffic: mostly golden, occasional corruption, restarts, resets
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk_i);
         restart_i = ($urandom_range(99) == 0);
         if ($urandom_range(39) == 0) begin
            pat = gold;
            if ($urandom_range(2) == 0) begin
               int k;
               k = $urandom_range(NF - 1);
               pat[k] = (k == 1 || k == 3) ? $urandom_range(255) : $urandom_range(1);
            end
            apply(pat);
         end
         if ($urandom_range(599) == 0) begin
            #2 rst_ni = 1'b0;
            @(negedge clk_i);
            rst_ni = 1'b1;
         end
      end
      restart_i = 1'b0;
      @(negedge clk_i);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
